// File: rtl/direct_map_pkg.sv
//------------------------------------------------------------------------------
// Module      : direct_map_pkg
// Description : Shared geometry and line record for the direct-mapped cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package direct_map_pkg;

  localparam int ADDR_W = 11;
  localparam int TAG_W  = 4;
  localparam int OFF_W  = ADDR_W - TAG_W;
  localparam int LINES  = 16;
  localparam int IDX_W  = $clog2(LINES);
  localparam int DATA_W = 8;

  // One cache line: valid flag, stored tag and payload.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

endpackage : direct_map_pkg

`default_nettype wire

// File: rtl/dm_tag_compare.sv
//------------------------------------------------------------------------------
// Module      : dm_tag_compare
// Description : Combinational hit detector for a single cache line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_tag_compare
  import direct_map_pkg::*;
(
  input  logic             i_line_valid,
  input  logic [TAG_W-1:0] i_line_tag,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_hit
);

  // A line hits only when it holds valid data for the requested tag.
  always_comb begin
    o_hit = i_line_valid && (i_line_tag == i_tag);
  end

endmodule : dm_tag_compare

`default_nettype wire

// File: rtl/direct_map_cache.sv
//------------------------------------------------------------------------------
// Module      : direct_map_cache
// Description : 16-line direct-mapped write-allocate tag/data store with a
//               combinational lookup path. Address bits between the index and
//               the tag are ignored, so such addresses alias to one line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module direct_map_cache
  import direct_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] dout,
  output logic              hit
);

  logic [TAG_W-1:0]       w_tag;
  logic [IDX_W-1:0]       w_idx;
  logic [OFF_W-IDX_W-1:0] w_unused_addr_bits;
  line_t                  w_sel_line;
  logic                   w_hit;

  line_t r_lines [LINES];

  // Split the address; the middle bits deliberately take no part in lookup.
  always_comb begin
    w_tag              = addr[ADDR_W-1 -: TAG_W];
    w_idx              = addr[IDX_W-1:0];
    w_unused_addr_bits = addr[OFF_W-1:IDX_W];
  end

  // Line store: reset clears every line, a write replaces the indexed line
  // unconditionally (no write-back, so the old contents are simply dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        r_lines[i] <= '0;
      end
    end else if (we) begin
      r_lines[w_idx] <= '{valid: 1'b1, tag: w_tag, data: din};
    end
  end

  // Select the indexed line for the combinational lookup.
  always_comb begin
    w_sel_line = r_lines[w_idx];
  end

  dm_tag_compare u_tag_compare (
    .i_line_valid (w_sel_line.valid),
    .i_line_tag   (w_sel_line.tag),
    .i_tag        (w_tag),
    .o_hit        (w_hit)
  );

  // Misses return zero data rather than whatever the line holds.
  always_comb begin
    hit  = w_hit;
    dout = w_hit ? w_sel_line.data : '0;
  end

endmodule : direct_map_cache

`default_nettype wire

// File: tb/tb_direct_map_cache.sv
//------------------------------------------------------------------------------
// Module      : tb_direct_map_cache
// Description : Self-checking bench for direct_map_cache with a per-index
//               reference model and directed plus random scenarios.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_direct_map_cache;

  logic        clk;
  logic        rst_n;
  logic [10:0] addr;
  logic [7:0]  din;
  logic        we;
  logic [7:0]  dout;
  logic        hit;

  int checks = 0;
  int passed = 0;

  // Reference model: one entry per index (address mod 16).
  bit         mv [16];
  logic [3:0] mt [16];
  logic [7:0] md [16];

  direct_map_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .din   (din),
    .we    (we),
    .dout  (dout),
    .hit   (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hit, dout} for an address under the current model state.
  function automatic logic [8:0] ref_lookup(input logic [10:0] a);
    int i;
    logic [3:0] t;
    i = int'(a) % 16;
    t = 4'(int'(a) / 128);
    if (mv[i] && mt[i] == t) return {1'b1, md[i]};
    return 9'h000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      mt[i] = 4'h0;
      md[i] = 8'h00;
    end
  endtask

  task automatic model_write(input logic [10:0] a, input logic [7:0] d);
    int i;
    i = int'(a) % 16;
    mv[i] = 1'b1;
    mt[i] = 4'(int'(a) / 128);
    md[i] = d;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    model_write(a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic set_addr(input logic [10:0] a);
    @(negedge clk);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 11'h000;
    din   = 8'h00;
    model_clear();
    #11;
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_during: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
    #1;
    rst_n = 1'b1;
    set_addr(11'h000);
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_after: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
  endtask

  task automatic test_fill();
    do_write(11'h080, 8'hA1);
    do_write(11'h101, 8'hB2);
    do_write(11'h182, 8'hC3);
    do_write(11'h203, 8'hD4);
    set_addr(11'h080);
    checks++;
    if (hit !== 1'b1 || dout !== 8'hA1)
      $display("FAIL fill_a1: hit=%b dout=%h required hit=1 dout=a1", hit, dout);
    else passed++;
    set_addr(11'h101);
    checks++;
    if (hit !== 1'b1 || dout !== 8'hB2)
      $display("FAIL fill_b2: hit=%b dout=%h required hit=1 dout=b2", hit, dout);
    else passed++;
    set_addr(11'h203);
    checks++;
    if (hit !== 1'b1 || dout !== 8'hD4)
      $display("FAIL fill_d4: hit=%b dout=%h required hit=1 dout=d4", hit, dout);
    else passed++;
  endtask

  task automatic test_cold_miss();
    set_addr(11'h784);
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL cold_miss: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
  endtask

  task automatic test_conflict();
    do_write(11'h480, 8'h9A);
    set_addr(11'h080);
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL conflict_old: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
    set_addr(11'h480);
    checks++;
    if (hit !== 1'b1 || dout !== 8'h9A)
      $display("FAIL conflict_new: hit=%b dout=%h required hit=1 dout=9a", hit, dout);
    else passed++;
  endtask

  task automatic test_alias_reset();
    do_write(11'h0B5, 8'h55);
    set_addr(11'h085);
    checks++;
    if (hit !== 1'b1 || dout !== 8'h55)
      $display("FAIL alias_hit: hit=%b dout=%h required hit=1 dout=55", hit, dout);
    else passed++;
    // Reset pulse mid-cycle with a write pending across the next edge.
    @(negedge clk);
    #2;
    addr  = 11'h085;
    din   = 8'h77;
    we    = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_immediate: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_blocks_write: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
    #2;
    we    = 1'b0;
    rst_n = 1'b1;
    set_addr(11'h085);
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00)
      $display("FAIL reset_after_pulse: hit=%b dout=%h required hit=0 dout=00", hit, dout);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [10:0] a;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a    = 11'(($urandom_range(0, 127) << 4) | i);
      addr = a;
      din  = 8'($urandom);
      we   = 1'b1;
      @(posedge clk);
      model_write(a, din);
    end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 11'($urandom_range(0, 2047));
      a[3:0] = 4'(i);
      set_addr(a);
      exp = ref_lookup(a);
      checks++;
      if ({hit, dout} !== exp)
        $display("FAIL b2b_idx%0d: addr=%h hit=%b dout=%h required hit=%b dout=%h",
                 i, a, hit, dout, exp[8], exp[7:0]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [8:0]  exp;
    logic [10:0] a;
    logic [7:0]  d;
    for (int n = 0; n < 60; n++) begin
      // Small tag range keeps hits frequent.
      a = 11'(($urandom_range(0, 3) << 7) | $urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        #1;
        exp = ref_lookup(a);
        checks++;
        if ({hit, dout} !== exp)
          $display("FAIL rand_prewrite: addr=%h hit=%b dout=%h required hit=%b dout=%h",
                   a, hit, dout, exp[8], exp[7:0]);
        else passed++;
        @(posedge clk);
        model_write(a, d);
        #1;
        we  = 1'b0;
        exp = ref_lookup(a);
        checks++;
        if ({hit, dout} !== exp)
          $display("FAIL rand_raw: addr=%h hit=%b dout=%h required hit=%b dout=%h",
                   a, hit, dout, exp[8], exp[7:0]);
        else passed++;
      end else begin
        set_addr(a);
        exp = ref_lookup(a);
        checks++;
        if ({hit, dout} !== exp)
          $display("FAIL rand_read: addr=%h hit=%b dout=%h required hit=%b dout=%h",
                   a, hit, dout, exp[8], exp[7:0]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cold_miss();
    test_conflict();
    test_alias_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_direct_map_cache

`default_nettype wire

// File: doc/direct_map_cache.md
Name: direct_map_cache

Overview:
- Single-level, direct-mapped, write-allocate cache tag/data store with 16 lines of 8-bit data.
- Writes update a line synchronously. Reads are combinational lookups that return the hit flag and data.
- Used as a standalone memory-hierarchy teaching block; no backing-memory interface. A miss returns hit=0 and dout=0.

Parameters:
- ADDR_W, 11, total address width.
- TAG_W, 4, tag field width, taken from addr[ADDR_W-1 -: TAG_W] (addr[10:7]).
- OFF_W, 7, width of the field below the tag (addr[6:0]).
- LINES, 16, number of cache lines. Must be a power of two, with LINES <= 2**OFF_W.
- IDX_W, $clog2(LINES) = 4, index bits actually used, taken from addr[IDX_W-1:0].
- DATA_W, 8, data width per line.

Ports:
- clk    input   1        rising-edge clock.
- rst_n  input   1        asynchronous active-low reset.
- addr   input   ADDR_W   lookup/write address.
- din    input   DATA_W   write data.
- we     input   1        write enable, sampled on the rising clk edge.
- dout   output  DATA_W   read data (combinational).
- hit    output  1        lookup hit (combinational).

Behaviour:
- Address split:
  - tag = addr[10:7].
  - idx = addr[3:0].
  - addr[6:4] is ignored: it takes no part in indexing or tag compare, so addresses differing only there alias to the same line.
- State per line: valid (1 b), tag (TAG_W), data (DATA_W).
- Reset: rst_n low immediately clears all valid bits, tags and data to 0. Therefore hit=0 and dout=0 while in reset and after release, until the first write. Reset asserted mid-operation overrides any write in that cycle.
- Write: on a rising clk with rst_n=1 and we=1, line[idx] gets valid=1, tag=addr tag, data=din.
  - An existing line with a different tag is overwritten unconditionally (direct-mapped replacement, no write-back).
  - Writing the same tag updates the data.
- Lookup (combinational, independent of we):
  - hit = valid[idx] && (tag_store[idx] == tag).
  - dout = hit ? data[idx] : 0.
- During a write cycle, hit/dout reflect contents before the edge. The new value is visible the same cycle after the edge settles, i.e. zero-cycle read-after-write on the next sample.
- Writes have one-edge latency; reads have zero latency.
- Back-to-back writes to different indices in consecutive cycles are all captured.
- Out-of-range conditions are impossible because idx always fits LINES.

Decomposition:
- Package direct_map_pkg holds ADDR_W, TAG_W, OFF_W, LINES, IDX_W, DATA_W, plus a line_t struct {valid, tag, data}.
- One natural sub-module, dm_tag_compare: a combinational valid/tag comparator producing hit for a given line. The line array and write logic stay in the top.

Test Plan:
1. Reset then lookup: assert rst_n=0 for 12 ns, release, read addr 0x000 -> hit=0, dout=0x00.
2. Fill: write (tag,idx)=(1,0)=A1, (2,1)=B2, (3,2)=C3, (4,3)=D4, using addr = tag<<7 | idx, one per cycle. Then read tag1/idx0 -> hit=1, dout=A1; read tag2/idx1 -> hit=1, dout=B2.
3. Cold miss: read tag 0xF, idx 4 (addr 0x784) -> hit=0, dout=0x00.
4. Conflict replacement: write tag 9, idx 0 (addr 0x480) with 9A. Then read tag1/idx0 (0x080) -> hit=0, dout=00; read 0x480 -> hit=1, dout=9A.
5. Aliasing and reset: write 0x0B5 (tag1, addr[6:4]=3, idx5) with 55, then read 0x085 -> hit=1, dout=55. Pulse rst_n low mid-cycle -> hit=0 immediately, and the next read of 0x085 misses.
